// File: rtl/m_axi_lite.sv
// m_axi_lite: single-outstanding AXI4-Lite master behind a simple command/response port.
// A transaction stuck longer than TIMEOUT_CYCLES is abandoned so a hung slave cannot lock the bus.
module m_axi_lite #(
    parameter int M_AXI_DATA_SIZE = 32,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       M_AXI_ACLK,
    input  logic                       M_AXI_ARESETN,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [31:0]                cmd_addr,
    input  logic [M_AXI_DATA_SIZE-1:0] cmd_wdata,
    output logic                       rsp_valid,
    output logic [M_AXI_DATA_SIZE-1:0] rsp_rdata,
    output logic [2:0]                 rsp_status,
    output logic [31:0]                M_AXI_LITE_AWADDR,
    output logic                       M_AXI_LITE_AWVALID,
    input  logic                       M_AXI_LITE_AWREADY,
    output logic [M_AXI_DATA_SIZE-1:0] M_AXI_LITE_WDATA,
    output logic                       M_AXI_LITE_WVALID,
    input  logic                       M_AXI_LITE_WREADY,
    input  logic [1:0]                 M_AXI_LITE_BRESP,
    input  logic                       M_AXI_LITE_BVALID,
    output logic                       M_AXI_LITE_BREADY,
    output logic [31:0]                M_AXI_LITE_ARADDR,
    output logic                       M_AXI_LITE_ARVALID,
    input  logic                       M_AXI_LITE_ARREADY,
    input  logic [M_AXI_DATA_SIZE-1:0] M_AXI_LITE_RDATA,
    input  logic [1:0]                 M_AXI_LITE_RRESP,
    input  logic                       M_AXI_LITE_RVALID,
    output logic                       M_AXI_LITE_RREADY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [31:0]                r_addr;
    logic [M_AXI_DATA_SIZE-1:0] r_wdata;
    logic                       r_cmd_ready;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_bready;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_rsp_valid;
    logic [M_AXI_DATA_SIZE-1:0] r_rsp_rdata;
    logic [2:0]                 r_rsp_status;

    logic w_timeout;
    logic w_aw_done;
    logic w_w_done;
    logic w_wr_addr_done;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_abort;

    assign w_timeout      = (r_state != S_IDLE) && (r_cnt >= CNT_LAST);
    assign w_aw_done      = !r_awvalid || M_AXI_LITE_AWREADY;
    assign w_w_done       = !r_wvalid || M_AXI_LITE_WREADY;
    assign w_wr_addr_done = (r_state == S_WR_REQ) && w_aw_done && w_w_done;
    assign w_b_hs         = (r_state == S_WR_RESP) && r_bready && M_AXI_LITE_BVALID;
    assign w_ar_hs        = (r_state == S_RD_REQ) && r_arvalid && M_AXI_LITE_ARREADY;
    assign w_r_hs         = r_rready && M_AXI_LITE_RVALID &&
                            (w_ar_hs || (r_state == S_RD_RESP));
    // A handshake landing on the expiry cycle wins over the timeout.
    assign w_abort        = w_timeout && !(w_wr_addr_done || w_b_hs || w_r_hs);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cmd_ready  <= 1'b1;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_cnt       <= '0;
                        if (cmd_we) begin
                            r_state   <= S_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_REQ;
                            r_arvalid <= 1'b1;
                            r_rready  <= 1'b1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (r_awvalid && M_AXI_LITE_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_LITE_WREADY)   r_wvalid  <= 1'b0;
                    if (w_wr_addr_done) begin
                        r_state  <= S_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready     <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_rsp_status <= {1'b0, M_AXI_LITE_BRESP};
                        r_cmd_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: ;
                default: r_state <= S_IDLE;
            endcase

            // Read completion and abort are shared across states; they override the case above.
            if (w_r_hs) begin
                r_rready     <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_rdata  <= M_AXI_LITE_RDATA;
                r_rsp_status <= {1'b0, M_AXI_LITE_RRESP};
                r_cmd_ready  <= 1'b1;
                r_state      <= S_IDLE;
            end
            if (w_abort) begin
                r_awvalid    <= 1'b0;
                r_wvalid     <= 1'b0;
                r_bready     <= 1'b0;
                r_arvalid    <= 1'b0;
                r_rready     <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_rdata  <= '0;
                r_rsp_status <= 3'b100;
                r_cmd_ready  <= 1'b1;
                r_state      <= S_IDLE;
            end
        end
    end

    assign cmd_ready          = r_cmd_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_rdata          = r_rsp_rdata;
    assign rsp_status         = r_rsp_status;
    assign M_AXI_LITE_AWADDR  = r_addr;
    assign M_AXI_LITE_AWVALID = r_awvalid;
    assign M_AXI_LITE_WDATA   = r_wdata;
    assign M_AXI_LITE_WVALID  = r_wvalid;
    assign M_AXI_LITE_BREADY  = r_bready;
    assign M_AXI_LITE_ARADDR  = r_addr;
    assign M_AXI_LITE_ARVALID = r_arvalid;
    assign M_AXI_LITE_RREADY  = r_rready;

endmodule

// File: tb/tb_m_axi_lite.sv
// Directed vector bench for m_axi_lite with a cycle-scheduled slave and TIMEOUT_CYCLES=8.
// Slave inputs are driven and outputs sampled on the falling clock edge.
module tb_m_axi_lite;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_status;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m_axi_lite #(.M_AXI_DATA_SIZE(32), .TIMEOUT_CYCLES(8)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .M_AXI_LITE_AWADDR(awaddr), .M_AXI_LITE_AWVALID(awvalid), .M_AXI_LITE_AWREADY(awready),
        .M_AXI_LITE_WDATA(wdata), .M_AXI_LITE_WVALID(wvalid), .M_AXI_LITE_WREADY(wready),
        .M_AXI_LITE_BRESP(bresp), .M_AXI_LITE_BVALID(bvalid), .M_AXI_LITE_BREADY(bready),
        .M_AXI_LITE_ARADDR(araddr), .M_AXI_LITE_ARVALID(arvalid), .M_AXI_LITE_ARREADY(arready),
        .M_AXI_LITE_RDATA(rdata), .M_AXI_LITE_RRESP(rresp), .M_AXI_LITE_RVALID(rvalid),
        .M_AXI_LITE_RREADY(rready)
    );

    // *_at: cycle after accept on which the slave acts (0 = never); exp_lat counts the same way.
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_at;
        int          w_at;
        int          b_at;
        int          ar_at;
        int          r_at;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [2:0]  exp_status;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    c;
        bit    got, aw_p, w_p, ar_p;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({t, ".cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        aw_p = v.we; w_p = v.we; ar_p = !v.we; got = 0; c = 1;
        while (!got && c <= 30) begin
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (v.we) begin
                    chk({t, ".awvalid"}, awvalid, aw_p);
                    chk({t, ".wvalid"}, wvalid, w_p);
                    chk({t, ".bready"}, bready, !aw_p && !w_p);
                    if (aw_p) chk({t, ".awaddr"}, awaddr, v.addr);
                    if (w_p)  chk({t, ".wdata"}, wdata, v.wdata);
                end else begin
                    chk({t, ".arvalid"}, arvalid, ar_p);
                    chk({t, ".rready"}, rready, 1);
                    if (ar_p) chk({t, ".araddr"}, araddr, v.addr);
                end
                awready = (v.aw_at == c);
                wready  = (v.w_at == c);
                bvalid  = (v.b_at != 0) && (c >= v.b_at);
                bresp   = v.resp;
                arready = (v.ar_at == c);
                rvalid  = (v.r_at != 0) && (c >= v.r_at);
                rresp   = v.resp;
                rdata   = v.rdata;
                if (aw_p && awready) aw_p = 0;
                if (w_p && wready)   w_p = 0;
                if (ar_p && arready) ar_p = 0;
                @(negedge clk);
                c++;
            end
        end
        clear_slave();
        chk({t, ".rsp_seen"}, got, 1);
        if (got) begin
            chk({t, ".latency"}, c, v.exp_lat);
            chk({t, ".status"}, rsp_status, v.exp_status);
            chk({t, ".rdata"}, rsp_rdata, v.exp_rdata);
            chk({t, ".cmd_ready_at_rsp"}, cmd_ready, 1);
            chk({t, ".bus_idle_at_rsp"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
            @(negedge clk);
            chk({t, ".single_pulse"}, rsp_valid, 0);
            chk({t, ".status_hold"}, rsp_status, v.exp_status);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 1, 1, 2, 0, 0, 2'b00, 32'h0, 3'b000, 32'h0, 3};
        vecs[1]  = '{1'b1, 32'h08, 32'h11223344, 4, 1, 5, 0, 0, 2'b00, 32'h0, 3'b000, 32'h0, 6};
        vecs[2]  = '{1'b1, 32'h0C, 32'h0BADF00D, 2, 5, 7, 0, 0, 2'b01, 32'h0, 3'b001, 32'h0, 8};
        vecs[3]  = '{1'b1, 32'h18, 32'h00000001, 3, 3, 4, 0, 0, 2'b00, 32'h0, 3'b000, 32'h0, 5};
        vecs[4]  = '{1'b1, 32'h1C, 32'h00000002, 0, 1, 0, 0, 0, 2'b00, 32'h0, 3'b100, 32'h0, 9};
        vecs[5]  = '{1'b1, 32'h20, 32'h00000003, 1, 1, 0, 0, 0, 2'b00, 32'h0, 3'b100, 32'h0, 9};
        vecs[6]  = '{1'b1, 32'h24, 32'h00000004, 1, 1, 8, 0, 0, 2'b10, 32'h0, 3'b010, 32'h0, 9};
        vecs[7]  = '{1'b0, 32'h10, 32'h0, 0, 0, 0, 1, 3, 2'b00, 32'h12345678, 3'b000, 32'h12345678, 4};
        vecs[8]  = '{1'b0, 32'h14, 32'h0, 0, 0, 0, 2, 2, 2'b10, 32'hA5A5A5A5, 3'b010, 32'hA5A5A5A5, 3};
        vecs[9]  = '{1'b0, 32'h30, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3'b100, 32'h0, 9};
        vecs[10] = '{1'b0, 32'h34, 32'h0, 0, 0, 0, 8, 9, 2'b00, 32'h77777777, 3'b100, 32'h0, 9};
        vecs[11] = '{1'b0, 32'h38, 32'h0, 0, 0, 0, 8, 8, 2'b11, 32'hCAFEF00D, 3'b011, 32'hCAFEF00D, 9};

        @(negedge clk);
        @(negedge clk);
        chk("reset.cmd_ready", cmd_ready, 1);
        chk("reset.bus", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("reset.addr_data", {awaddr, wdata}, 0);
        chk("reset.rsp", {rsp_status, rsp_rdata}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset mid-write: outputs must clear without waiting for a clock edge.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'hFFFF0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.awvalid_before", awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.bus", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("rst_mid.cmd_ready", cmd_ready, 1);
        chk("rst_mid.addr_data", {awaddr, wdata}, 0);
        chk("rst_mid.rsp", {rsp_status, rsp_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid.no_rsp", {rsp_valid, awvalid}, 0);
        end

        // Read error followed by a write accepted in the response cycle.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40;
        @(negedge clk);
        cmd_valid = 1'b0;
        arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h00000055;
        @(negedge clk);
        clear_slave();
        chk("b2b.rd_rsp_valid", rsp_valid, 1);
        chk("b2b.rd_status", rsp_status, 3'b010);
        chk("b2b.rd_rdata", rsp_rdata, 32'h55);
        chk("b2b.cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h99;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0;
        chk("b2b.accepted", {awvalid, wvalid, cmd_ready, rsp_valid}, 4'b1100);
        chk("b2b.awaddr", awaddr, 32'h44);
        chk("b2b.bready_low", bready, 0);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        clear_slave();
        chk("b2b.bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        clear_slave();
        chk("b2b.wr_rsp_valid", rsp_valid, 1);
        chk("b2b.wr_rsp", {rsp_status, rsp_rdata}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_axi_lite.md
M_AXI_LITE -- requirements
Module: m_axi_lite

Interface
REQ-001 M_AXI_DATA_SIZE, default 32, width of data buses (cmd_wdata, rsp_rdata, WDATA, RDATA).
REQ-002 TIMEOUT_CYCLES, default 255, maximum cycles a transaction may remain outstanding before it is abandoned.
REQ-003 M_AXI_ACLK  input  1  single clock; all logic is on the rising edge.
REQ-004 M_AXI_ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  user command request.
REQ-006 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-007 cmd_we  input  1  1 = write, 0 = read; sampled at command accept.
REQ-008 cmd_addr  input  32  byte address; sampled at command accept.
REQ-009 cmd_wdata  input  DATA  write data; sampled at command accept.
REQ-010 rsp_valid  output  1  one-cycle pulse: transaction finished.
REQ-011 rsp_rdata  output  DATA  read data; 0 for writes and timeouts.
REQ-012 rsp_status  output  3  [1:0] = BRESP or RRESP; [2] = timeout.
REQ-013 M_AXI_LITE_AWADDR  output  32  write address.
REQ-014 M_AXI_LITE_AWVALID  output  1  write address valid.
REQ-015 M_AXI_LITE_AWREADY  input  1  write address accepted.
REQ-016 M_AXI_LITE_WDATA  output  DATA  write data.
REQ-017 M_AXI_LITE_WVALID  output  1  write data valid.
REQ-018 M_AXI_LITE_WREADY  input  1  write data accepted.
REQ-019 M_AXI_LITE_BRESP  input  2  write response code.
REQ-020 M_AXI_LITE_BVALID  input  1  write response valid.
REQ-021 M_AXI_LITE_BREADY  output  1  master ready for the write response.
REQ-022 M_AXI_LITE_ARADDR  output  32  read address.
REQ-023 M_AXI_LITE_ARVALID  output  1  read address valid.
REQ-024 M_AXI_LITE_ARREADY  input  1  read address accepted.
REQ-025 M_AXI_LITE_RDATA  input  DATA  read data.
REQ-026 M_AXI_LITE_RRESP  input  2  read response code.
REQ-027 M_AXI_LITE_RVALID  input  1  read data valid.
REQ-028 M_AXI_LITE_RREADY  output  1  master ready for read data.

Function
REQ-029 The block SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_RESP, with one transaction outstanding at a time.
- Command accept: the cycle where cmd_valid && cmd_ready.
- On accept: latch address and data; go to WR_REQ if cmd_we=1, else RD_REQ.
- All outputs are registered.
REQ-030 WR_REQ SHALL assert AWVALID and WVALID together from the cycle after accept.
- Each of AWVALID and WVALID drops on the cycle after its own handshake, independently.
- AWADDR and WDATA stay stable while the matching VALID is high.
- The block moves to WR_RESP once both handshakes are done; they may complete in the same cycle or in either order.
REQ-031 WR_RESP SHALL assert BREADY only in this state; BREADY is never high in WR_REQ.
- On BVALID && BREADY: capture BRESP and return to IDLE.
REQ-032 RD_REQ SHALL assert ARVALID, and RREADY SHALL be high in both RD_REQ and RD_RESP.
- On the ARREADY handshake: drop ARVALID and go to RD_RESP.
- If RVALID is seen in the same cycle as ARREADY, or later in RD_RESP, capture RDATA and RRESP and return to IDLE.
REQ-033 rsp_valid SHALL pulse for exactly one cycle, on the cycle after the B or R handshake.
- rsp_rdata and rsp_status are valid during that pulse and hold until the next response.
- cmd_ready returns high in that same cycle.
REQ-034 The timeout counter SHALL clear on command accept and increment every cycle while not in IDLE.
- When the count reaches TIMEOUT_CYCLES: deassert all VALID/READY outputs, pulse rsp_valid with rsp_status=3'b100 and rsp_rdata=0, and go to IDLE.
- This violates the AXI rule against dropping VALID; it is intentional, for bus-hang recovery.
REQ-035 A handshake in the same cycle the timeout fires SHALL take priority, giving a normal response.
REQ-036 Non-OKAY BRESP/RRESP values SHALL be reported unchanged in rsp_status[1:0] with [2]=0.
- The block itself does not retry.

Reset
REQ-037 While M_AXI_ARESETN=0, asynchronously:
- FSM = IDLE; all AXI VALID/READY outputs and rsp_valid = 0; cmd_ready = 1.
- Address, data, rsp_rdata, rsp_status and the counter = 0.
- A reset mid-transaction abandons it with no response.

Verification
REQ-038 Write: cmd addr=0x04, data=0xDEADBEEF; slave takes AW and W in the same cycle, BRESP=00 -> AWADDR=0x04, WDATA=0xDEADBEEF; one rsp_valid with status=000.
REQ-039 Write, staggered: WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID holds; BREADY rises only after both handshakes.
REQ-040 Read: addr=0x10; slave returns RDATA=0x12345678, RRESP=00 two cycles after ARREADY -> rsp_rdata=0x12345678, status=000.
REQ-041 Read error: RRESP=10 -> rsp_status=010; then a back-to-back write is accepted in the cycle rsp_valid is high.
REQ-042 Timeout: TIMEOUT_CYCLES=8 and the slave never asserts ARREADY -> ARVALID drops after 8 cycles, rsp_status=100, rsp_rdata=0; a reset asserted mid-write clears all outputs immediately.
